// File: rtl/sram_b_stream_ctrl_if.sv
// Stream-side bundle for sram_b_stream_ctrl:
// write requests, read requests and read responses.
interface sram_b_stream_ctrl_if #(
  parameter int ABITS = 18,
  parameter int DBITS = 8
);
  logic             wr_valid;
  logic             wr_ready;
  logic [ABITS-1:0] wr_addr;
  logic [DBITS-1:0] wr_data;
  logic [DBITS-1:0] wr_mask;

  logic             rd_req_valid;
  logic             rd_req_ready;
  logic [ABITS-1:0] rd_req_addr;

  logic             rd_rsp_valid;
  logic             rd_rsp_ready;
  logic [DBITS-1:0] rd_rsp_data;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask,
    output rd_req_valid, rd_req_addr,
    output rd_rsp_ready,
    input  wr_ready, rd_req_ready,
    input  rd_rsp_valid, rd_rsp_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mask,
    input  rd_req_valid, rd_req_addr,
    input  rd_rsp_ready,
    output wr_ready, rd_req_ready,
    output rd_rsp_valid, rd_rsp_data
  );
endinterface

// File: rtl/sram_b_stream_ctrl.sv
// Stream-to-port controller for 1W/1R sram_b memories:
// registered port accesses, credited 4-entry response FIFO.
module sram_b_stream_ctrl #(
  parameter int ABITS = 18,
  parameter int DBITS = 8
) (
  input  logic             CLK,
  input  logic             RST,
  sram_b_stream_ctrl_if.slave bus,
  output logic             CE0,
  output logic [ABITS-1:0] A0,
  output logic [DBITS-1:0] D0,
  output logic             WE0,
  output logic [DBITS-1:0] WEM0,
  output logic             CE1,
  output logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] Q1,
  output logic [15:0]      hazard_stalls
);

  logic       same_addr;
  logic       wr_acc;
  logic       rd_acc;
  logic       push;
  logic       pop;
  logic [2:0] outstanding;
  logic [1:0] pipe_v;

  logic [DBITS-1:0] fifo_mem [4];
  logic [1:0]       wp;
  logic [1:0]       rp;
  logic [2:0]       cnt;

  // A same-address write always wins; the read retries next cycle.
  assign same_addr = bus.wr_valid &&
                     (bus.wr_addr == bus.rd_req_addr);

  assign bus.wr_ready     = !RST;
  assign bus.rd_req_ready = !RST &&
                            (outstanding < 3'd4) &&
                            !same_addr;

  assign wr_acc = bus.wr_valid && bus.wr_ready;
  assign rd_acc = bus.rd_req_valid && bus.rd_req_ready;
  assign push   = pipe_v[1];
  assign pop    = bus.rd_rsp_valid && bus.rd_rsp_ready;

  assign bus.rd_rsp_valid = (cnt != 3'd0);
  assign bus.rd_rsp_data  = fifo_mem[rp];
  assign CE1              = pipe_v[0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      CE0  <= 1'b0;
      WE0  <= 1'b0;
      A0   <= '0;
      D0   <= '0;
      WEM0 <= '0;
    end else begin
      CE0 <= wr_acc;
      WE0 <= wr_acc;
      if (wr_acc) begin
        A0   <= bus.wr_addr;
        D0   <= bus.wr_data;
        WEM0 <= bus.wr_mask;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pipe_v <= 2'b00;
      A1     <= '0;
    end else begin
      pipe_v <= {pipe_v[0], rd_acc};
      if (rd_acc) begin
        A1 <= bus.rd_req_addr;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      outstanding <= 3'd0;
    end else begin
      unique case ({rd_acc, pop})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wp] <= Q1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wp  <= 2'd0;
      rp  <= 2'd0;
      cnt <= 3'd0;
    end else begin
      if (push) begin
        wp <= wp + 2'd1;
      end
      if (pop) begin
        rp <= rp + 2'd1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hazard_stalls <= 16'd0;
    end else if (same_addr && bus.rd_req_valid &&
                 (hazard_stalls != 16'hFFFF)) begin
      hazard_stalls <= hazard_stalls + 16'd1;
    end
  end

  a_no_overflow: assert property (
    @(posedge CLK) disable iff (RST)
    !(push && (cnt == 3'd4))
  );

endmodule

// File: tb/tb_sram_b_stream_ctrl.sv
// Randomized scoreboard bench for sram_b_stream_ctrl
// with a behavioural sram_b model on the port side.
module tb_sram_b_stream_ctrl;
  localparam int AB = 18;
  localparam int DB = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CE0, WE0, CE1;
  logic [AB-1:0] A0, A1;
  logic [DB-1:0] D0, WEM0;
  logic [DB-1:0] Q1 = '0;
  logic [15:0]   hazard_stalls;

  int errors = 0;
  int checks = 0;
  int rsp_cnt = 0;

  logic [DB-1:0] exp_q [$];
  logic [DB-1:0] ref_mem [int];
  logic [DB-1:0] sram [0:(1<<AB)-1];
  logic [15:0]   hz_m = 16'd0;

  sram_b_stream_ctrl_if #(.ABITS(AB), .DBITS(DB)) bus();

  sram_b_stream_ctrl #(.ABITS(AB), .DBITS(DB)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .bus          (bus.slave),
    .CE0          (CE0),
    .A0           (A0),
    .D0           (D0),
    .WE0          (WE0),
    .WEM0         (WEM0),
    .CE1          (CE1),
    .A1           (A1),
    .Q1           (Q1),
    .hazard_stalls(hazard_stalls)
  );

  always #5 CLK = ~CLK;

  initial begin
    for (int i = 0; i < (1 << AB); i++) sram[i] = '0;
  end

  always @(posedge CLK) begin
    if (CE0 && WE0)
      sram[A0] <= (sram[A0] & ~WEM0) | (D0 & WEM0);
    if (CE1)
      Q1 <= sram[A1];
  end

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [DB-1:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return '0;
  endfunction

  // Monitor: spec-level model of credits, hazards and data.
  always @(negedge CLK) begin
    logic hz_now;
    logic exp_rdy;
    hz_now = bus.wr_valid && bus.rd_req_valid &&
             (bus.wr_addr == bus.rd_req_addr);
    if (RST) begin
      exp_q.delete();
      hz_m = 16'd0;
    end else begin
      exp_rdy = (exp_q.size() < 4) &&
                !(bus.wr_valid &&
                  bus.wr_addr == bus.rd_req_addr);
      chk("rd_req_ready", bus.rd_req_ready, exp_rdy);
      chk("wr_ready", bus.wr_ready, 1);
      chk("hazard_stalls", hazard_stalls, hz_m);
      if (hz_now && hz_m != 16'hFFFF) hz_m++;
      if (bus.wr_valid && bus.wr_ready)
        ref_mem[bus.wr_addr] =
          (ref_rd(bus.wr_addr) & ~bus.wr_mask) |
          (bus.wr_data & bus.wr_mask);
      if (bus.rd_rsp_valid && bus.rd_rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got %0h expected none",
                   bus.rd_rsp_data);
        end else begin
          chk("rsp_data", bus.rd_rsp_data, exp_q.pop_front());
        end
      end
      if (bus.rd_req_valid && bus.rd_req_ready)
        exp_q.push_back(ref_rd(bus.rd_req_addr));
    end
    if (CE0 && CE1)
      chk("port_conflict", WE0 && (A0 == A1), 0);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.wr_valid     = 1'b0;
    bus.rd_req_valid = 1'b0;
  endtask

  task automatic wr(input int a, input int d, input int m);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AB'(a);
    bus.wr_data  = DB'(d);
    bus.wr_mask  = DB'(m);
  endtask

  task automatic rd(input int a);
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = AB'(a);
  endtask

  task automatic wait_drain();
    idle();
    bus.rd_rsp_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++)
      tick();
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int idx;
    int acc;
    int r0;
    logic take;

    RST = 1'b1;
    wr(1, 8'h11, 8'hFF);
    rd(2);
    bus.rd_rsp_ready = 1'b1;
    repeat (3) tick();
    chk("rst_CE0", CE0, 0);
    chk("rst_WE0", WE0, 0);
    chk("rst_CE1", CE1, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_rd_req_ready", bus.rd_req_ready, 0);
    chk("rst_rsp_valid", bus.rd_rsp_valid, 0);
    chk("rst_hazard", hazard_stalls, 0);
    idle();
    RST = 1'b0;
    tick();

    wr(32'h00123, 8'hA5, 8'hFF);
    tick();
    chk("wr_CE0", CE0, 1);
    chk("wr_WE0", WE0, 1);
    chk("wr_A0", A0, 32'h00123);
    chk("wr_D0", D0, 32'hA5);
    chk("wr_WEM0", WEM0, 32'hFF);
    bus.wr_valid = 1'b0;
    rd(32'h00123);
    tick();
    bus.rd_req_valid = 1'b0;
    chk("wr_CE0_idle", CE0, 0);
    chk("wr_A0_hold", A0, 32'h00123);
    chk("rsp_t2", bus.rd_rsp_valid, 0);
    tick();
    chk("rsp_t3", bus.rd_rsp_valid, 0);
    tick();
    chk("rsp_t4", bus.rd_rsp_valid, 1);
    chk("rsp_t4_data", bus.rd_rsp_data, 32'hA5);
    wait_drain();

    wr(5, 8'hFF, 8'hFF);
    tick();
    wr(5, 8'h00, 8'h0F);
    tick();
    bus.wr_valid = 1'b0;
    rd(5);
    tick();
    bus.rd_req_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.rd_rsp_valid; i++)
      tick();
    chk("mask_data", bus.rd_rsp_data, 32'hF0);
    wait_drain();

    for (int i = 0; i < 8; i++) begin
      wr(i, 8'h10 + i, 8'hFF);
      tick();
    end
    idle();
    bus.rd_rsp_ready = 1'b0;
    idx = 0;
    acc = 0;
    r0 = rsp_cnt;
    for (int c = 0; c < 10; c++) begin
      rd(idx);
      #1;
      take = bus.rd_req_ready;
      tick();
      if (take) begin
        idx++;
        acc++;
      end
    end
    rd(idx);
    #1;
    chk("bp_accepted", acc, 4);
    chk("bp_ready_low", bus.rd_req_ready, 0);
    bus.rd_rsp_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      rd(idx);
      #1;
      take = bus.rd_req_ready;
      tick();
      if (take) idx++;
    end
    wait_drain();
    chk("bp_rsp_count", rsp_cnt - r0, 8);

    wr(32'h3FFFF, 8'h3C, 8'hFF);
    rd(32'h3FFFF);
    #1;
    chk("hz_ready_low", bus.rd_req_ready, 0);
    tick();
    bus.wr_valid = 1'b0;
    #1;
    chk("hz_count", hazard_stalls, 1);
    chk("hz_ready_next", bus.rd_req_ready, 1);
    tick();
    wait_drain();

    bus.rd_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd(i);
      tick();
    end
    idle();
    tick();
    chk("mid_queued", bus.rd_rsp_valid, 1);
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    #1;
    chk("mid_rsp_valid", bus.rd_rsp_valid, 0);
    chk("mid_ready", bus.rd_req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_stale", bus.rd_rsp_valid, 0);
    end
    wr(9, 8'h77, 8'hFF);
    tick();
    idle();
    rd(9);
    bus.rd_rsp_ready = 1'b1;
    r0 = rsp_cnt;
    tick();
    wait_drain();
    chk("mid_one_rsp", rsp_cnt - r0, 1);

    for (int c = 0; c < 400; c++) begin
      bus.wr_valid     = 1'($urandom);
      bus.wr_addr      = AB'($urandom_range(0, 7));
      bus.wr_data      = DB'($urandom);
      bus.wr_mask      = DB'($urandom);
      bus.rd_req_valid = 1'($urandom);
      bus.rd_req_addr  = AB'($urandom_range(0, 7));
      bus.rd_rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
